// File: rtl/cpu_stack_file.sv
// ----------------------------------------------------------------------------
// cpu_stack_file
//
// Operand stack for the stack-machine CPU core. The writeback stage pushes
// and pops the architectural data stack. Decode sees the top two entries.
//
// Each cycle the stack can pop a number of entries, push one entry, or both.
// Popping and pushing in the same cycle replaces the popped entries with the
// pushed value. A flush empties the stack.
//
// An update that would pop more entries than the stack holds is rejected as a
// whole, and it sets the sticky underflow flag. An update that would grow the
// stack past DEPTH is also rejected as a whole, and it sets the sticky
// overflow flag. A high-watermark counter records the deepest the stack has
// been since reset or since the last error clear.
//
// Handshake: none. Every input is sampled on every rising edge of clk, and
// there is no back-pressure. An update presented in cycle t is visible on all
// outputs in cycle t+1. All outputs are decoded from registered state only,
// so no input reaches an output combinationally.
//
// Ports
//   clk                rising-edge clock
//   rst                asynchronous, active-high reset
//   st__push           push st__to_push this cycle
//   st__to_push        value to push
//   st__pop            pop st__to_pop entries this cycle
//   st__to_pop         pop count (0 = no pop)
//   st__flush          discard all entries (overrides push/pop)
//   st__err_clear      clear both error flags and re-seed the high-watermark
//   st__top_0          top entry, 0 when the stack is empty
//   st__top_1          second entry, 0 when depth < 2
//   st__depth          current entry count
//   st__empty          depth == 0
//   st__full           depth == DEPTH
//   st__max_depth      high-watermark of depth
//   st__err_overflow   sticky: an update was rejected for exceeding DEPTH
//   st__err_underflow  sticky: a pop was rejected for exceeding depth
// ----------------------------------------------------------------------------
module cpu_stack_file #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 64,
    parameter int POP_W = 11,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st__push,
    input  logic [WIDTH-1:0] st__to_push,
    input  logic             st__pop,
    input  logic [POP_W-1:0] st__to_pop,
    input  logic             st__flush,
    input  logic             st__err_clear,
    output logic [WIDTH-1:0] st__top_0,
    output logic [WIDTH-1:0] st__top_1,
    output logic [CNT_W-1:0] st__depth,
    output logic             st__empty,
    output logic             st__full,
    output logic [CNT_W-1:0] st__max_depth,
    output logic             st__err_overflow,
    output logic             st__err_underflow
);

    // Width of a storage index.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Width of the depth arithmetic. It must hold the zero-extended pop count
    // and the current depth, plus one spare bit so that d + p never wraps
    // before the comparisons are made.
    localparam int EXT_W = (((POP_W + 1) > CNT_W) ? (POP_W + 1) : CNT_W) + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] depth_q, depth_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    // Entry storage. Index 0 is the bottom of the stack. It is deliberately
    // not reset. Entries at or above depth_q are stale, and they are never
    // shown on an output.
    logic [WIDTH-1:0] mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Update decode
    // ------------------------------------------------------------------
    logic [EXT_W-1:0] n_ext;      // effective pop count
    logic [EXT_W-1:0] d_ext;      // current depth, widened
    logic [EXT_W-1:0] next_ext;   // d - n + p, meaningful only without underflow
    logic             underflow;
    logic             overflow;
    logic             legal;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [CNT_W-1:0] max_base;

    always_comb begin
        n_ext     = '0;
        d_ext     = EXT_W'(depth_q);
        next_ext  = '0;
        underflow = 1'b0;
        overflow  = 1'b0;
        legal     = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        depth_d   = depth_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        max_base  = max_q;
        max_d     = max_q;

        if (st__pop) begin
            n_ext = EXT_W'(st__to_pop);
        end

        next_ext = d_ext + EXT_W'(st__push) - n_ext;

        // A flush takes priority, so it can never raise an error. Overflow is
        // only considered when the pop itself fits.
        underflow = !st__flush && (n_ext > d_ext);
        overflow  = !st__flush && !underflow && (next_ext > EXT_W'(DEPTH));
        legal     = !st__flush && !underflow && !overflow;

        // When a legal update pushes, the new entry lands at index d - n,
        // which is next_ext - 1. This is also the replace case.
        wr_en  = legal && st__push;
        wr_idx = IDX_W'(next_ext - EXT_W'(1));

        if (st__flush) begin
            depth_d = '0;
        end else if (legal) begin
            depth_d = CNT_W'(next_ext);
        end

        // Clear first, then set. An error raised in the same cycle as a clear
        // therefore survives.
        if (st__err_clear) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (overflow) begin
            ovf_d = 1'b1;
        end
        if (underflow) begin
            unf_d = 1'b1;
        end

        // A clear re-seeds the watermark from the post-update depth. The
        // watermark otherwise only rises, so a flush never lowers it.
        if (st__err_clear) begin
            max_base = depth_d;
        end
        max_d = (depth_d > max_base) ? depth_d : max_base;
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q <= '0;
            max_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            max_q   <= max_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage (no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= st__to_push;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only, with no push bypass.
    // Invalid entries are masked to zero.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] top0_idx;
    logic [IDX_W-1:0] top1_idx;
    logic             top0_vld;
    logic             top1_vld;

    always_comb begin
        top0_idx = IDX_W'(depth_q - CNT_W'(1));
        top1_idx = IDX_W'(depth_q - CNT_W'(2));
        top0_vld = (depth_q >= CNT_W'(1));
        top1_vld = (depth_q >= CNT_W'(2));

        st__top_0 = '0;
        st__top_1 = '0;
        if (top0_vld) begin
            st__top_0 = mem_q[top0_idx];
        end
        if (top1_vld) begin
            st__top_1 = mem_q[top1_idx];
        end
    end

    assign st__depth         = depth_q;
    assign st__empty         = (depth_q == '0);
    assign st__full          = (depth_q == CNT_W'(DEPTH));
    assign st__max_depth     = max_q;
    assign st__err_overflow  = ovf_q;
    assign st__err_underflow = unf_q;

endmodule

// File: tb/tb_cpu_stack_file.sv
// ----------------------------------------------------------------------------
// tb_cpu_stack_file
//
// Bench for cpu_stack_file with DEPTH=4 and WIDTH=35.
//   - A table of directed vectors. Each vector carries its inputs and the
//     expected outputs after the next clock edge.
//   - A hand-written asynchronous reset, asserted mid-cycle.
//   - Randomized traffic checked against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_cpu_stack_file;

    localparam int W     = 35;
    localparam int D     = 4;
    localparam int PW    = 11;
    localparam int CW    = 3;
    localparam int N_RND = 500;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    always #5 clk = ~clk;

    logic          push;
    logic [W-1:0]  to_push;
    logic          pop;
    logic [PW-1:0] to_pop;
    logic          flush;
    logic          err_clear;
    logic [W-1:0]  top_0;
    logic [W-1:0]  top_1;
    logic [CW-1:0] depth;
    logic          empty;
    logic          full;
    logic [CW-1:0] max_depth;
    logic          err_ovf;
    logic          err_unf;

    cpu_stack_file #(.WIDTH(W), .DEPTH(D), .POP_W(PW)) dut (
        .clk               (clk),
        .rst               (rst),
        .st__push          (push),
        .st__to_push       (to_push),
        .st__pop           (pop),
        .st__to_pop        (to_pop),
        .st__flush         (flush),
        .st__err_clear     (err_clear),
        .st__top_0         (top_0),
        .st__top_1         (top_1),
        .st__depth         (depth),
        .st__empty         (empty),
        .st__full          (full),
        .st__max_depth     (max_depth),
        .st__err_overflow  (err_ovf),
        .st__err_underflow (err_unf)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters and compare helper
    // ------------------------------------------------------------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue with the back as the top of the stack
    // ------------------------------------------------------------------
    logic [W-1:0] m_q[$];
    int           m_max;
    bit           m_ovf;
    bit           m_unf;

    task automatic model_reset();
        m_q.delete();
        m_max = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic model_step(input bit p, input logic [W-1:0] v, input bit po,
                              input int n_in, input bit fl, input bit cl);
        int  n;
        int  d;
        bit  set_ovf;
        bit  set_unf;
        n       = po ? n_in : 0;
        d       = m_q.size();
        set_ovf = 0;
        set_unf = 0;
        if (fl) begin
            m_q.delete();
        end else if (n > d) begin
            set_unf = 1;
        end else if (d - n + int'(p) > D) begin
            set_ovf = 1;
        end else begin
            repeat (n) void'(m_q.pop_back());
            if (p) m_q.push_back(v);
        end
        if (cl) begin
            m_ovf = 0;
            m_unf = 0;
            m_max = m_q.size();
        end
        if (set_ovf) m_ovf = 1;
        if (set_unf) m_unf = 1;
        if (m_q.size() > m_max) m_max = m_q.size();
    endtask

    task automatic check_model(input string tag);
        logic [W-1:0] e0;
        logic [W-1:0] e1;
        int           sz;
        sz = m_q.size();
        e0 = (sz >= 1) ? m_q[sz-1] : '0;
        e1 = (sz >= 2) ? m_q[sz-2] : '0;
        chk({tag, " depth"}, 64'(depth), 64'(sz));
        chk({tag, " top0"},  64'(top_0), 64'(e0));
        chk({tag, " top1"},  64'(top_1), 64'(e1));
        chk({tag, " empty"}, 64'(empty), 64'(sz == 0));
        chk({tag, " full"},  64'(full),  64'(sz == D));
        chk({tag, " max"},   64'(max_depth), 64'(m_max));
        chk({tag, " ovf"},   64'(err_ovf), 64'(m_ovf));
        chk({tag, " unf"},   64'(err_unf), 64'(m_unf));
    endtask

    // ------------------------------------------------------------------
    // Driver: present one update, let the edge take it, sample 1 ns later
    // ------------------------------------------------------------------
    task automatic set_idle();
        push      = 1'b0;
        to_push   = '0;
        pop       = 1'b0;
        to_pop    = '0;
        flush     = 1'b0;
        err_clear = 1'b0;
    endtask

    task automatic apply(input bit p, input logic [W-1:0] v, input bit po,
                         input logic [PW-1:0] n, input bit fl, input bit cl);
        push      = p;
        to_push   = v;
        pop       = po;
        to_pop    = n;
        flush     = fl;
        err_clear = cl;
        @(posedge clk);
        model_step(p, v, po, int'(n), fl, cl);
        #1;
        set_idle();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " depth"}, 64'(depth), 64'd0);
        chk({tag, " top0"},  64'(top_0), 64'd0);
        chk({tag, " top1"},  64'(top_1), 64'd0);
        chk({tag, " empty"}, 64'(empty), 64'd1);
        chk({tag, " full"},  64'(full),  64'd0);
        chk({tag, " max"},   64'(max_depth), 64'd0);
        chk({tag, " ovf"},   64'(err_ovf), 64'd0);
        chk({tag, " unf"},   64'(err_unf), 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit            p;
        logic [W-1:0]  v;
        bit            po;
        logic [PW-1:0] n;
        bit            fl;
        bit            cl;
        int            e_depth;
        logic [W-1:0]  e_top0;
        logic [W-1:0]  e_top1;
        bit            e_ovf;
        bit            e_unf;
        int            e_max;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit p, logic [W-1:0] v, bit po, logic [PW-1:0] n,
                                bit fl, bit cl, int ed, logic [W-1:0] e0,
                                logic [W-1:0] e1, bit eo, bit eu, int em);
        vec_t r;
        r.p = p;   r.v = v;   r.po = po;   r.n = n;   r.fl = fl;   r.cl = cl;
        r.e_depth = ed;  r.e_top0 = e0;  r.e_top1 = e1;
        r.e_ovf = eo;    r.e_unf = eu;   r.e_max = em;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [63:0] rv;
        bit          rp;
        bit          rpo;
        logic [PW-1:0] rn;
        bit          rfl;
        bit          rcl;
        string       tag;

        set_idle();
        model_reset();
        #2 rst = 1'b1;
        #1 check_reset_values("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        //          p  val        po n       fl cl  dep top0       top1       ovf unf max
        tbl.push_back(mk(1, 35'h1,      0, 11'd0,   0, 0,  1, 35'h1,    35'h0,   0, 0, 1));
        tbl.push_back(mk(1, 35'h2,      0, 11'd0,   0, 0,  2, 35'h2,    35'h1,   0, 0, 2));
        tbl.push_back(mk(1, 35'h3,      0, 11'd0,   0, 0,  3, 35'h3,    35'h2,   0, 0, 3));
        tbl.push_back(mk(1, 35'h7A,     1, 11'd2,   0, 0,  2, 35'h7A,   35'h1,   0, 0, 3));
        tbl.push_back(mk(1, 35'h4,      0, 11'd0,   0, 0,  3, 35'h4,    35'h7A,  0, 0, 3));
        tbl.push_back(mk(1, 35'h5,      0, 11'd0,   0, 0,  4, 35'h5,    35'h4,   0, 0, 4));
        tbl.push_back(mk(1, 35'h9,      0, 11'd0,   0, 0,  4, 35'h5,    35'h4,   1, 0, 4));
        tbl.push_back(mk(1, 35'hB,      1, 11'd1,   0, 0,  4, 35'hB,    35'h4,   1, 0, 4));
        tbl.push_back(mk(0, 35'h0,      1, 11'd3,   0, 0,  1, 35'h1,    35'h0,   1, 0, 4));
        tbl.push_back(mk(0, 35'h0,      1, 11'd2,   0, 0,  1, 35'h1,    35'h0,   1, 1, 4));
        tbl.push_back(mk(0, 35'h0,      1, 11'd2,   0, 1,  1, 35'h1,    35'h0,   0, 1, 1));
        tbl.push_back(mk(0, 35'h0,      0, 11'd0,   0, 1,  1, 35'h1,    35'h0,   0, 0, 1));
        tbl.push_back(mk(1, 35'h6,      0, 11'd0,   0, 0,  2, 35'h6,    35'h1,   0, 0, 2));
        tbl.push_back(mk(1, 35'h8,      0, 11'd0,   0, 0,  3, 35'h8,    35'h6,   0, 0, 3));
        tbl.push_back(mk(1, 35'h1F,     0, 11'd0,   1, 0,  0, 35'h0,    35'h0,   0, 0, 3));
        tbl.push_back(mk(0, 35'h0,      1, 11'd0,   0, 0,  0, 35'h0,    35'h0,   0, 0, 3));
        tbl.push_back(mk(0, 35'h0,      0, 11'h7FF, 0, 0,  0, 35'h0,    35'h0,   0, 0, 3));
        tbl.push_back(mk(1, 35'h4_0000_00A1, 0, 11'd0, 0, 0, 1, 35'h4_0000_00A1, 35'h0, 0, 0, 3));
        tbl.push_back(mk(1, 35'h7_FFFF_FFFF, 0, 11'd0, 0, 0, 2, 35'h7_FFFF_FFFF, 35'h4_0000_00A1, 0, 0, 3));
        tbl.push_back(mk(1, 35'hA3,     0, 11'd0,   0, 0,  3, 35'hA3,   35'h7_FFFF_FFFF, 0, 0, 3));
        tbl.push_back(mk(1, 35'hA4,     0, 11'd0,   0, 0,  4, 35'hA4,   35'hA3,  0, 0, 4));
        tbl.push_back(mk(1, 35'hFF,     0, 11'd0,   0, 0,  4, 35'hA4,   35'hA3,  1, 0, 4));
        tbl.push_back(mk(0, 35'h0,      1, 11'h7FF, 0, 0,  4, 35'hA4,   35'hA3,  1, 1, 4));
        tbl.push_back(mk(0, 35'h0,      1, 11'd2,   0, 0,  2, 35'h7_FFFF_FFFF, 35'h4_0000_00A1, 1, 1, 4));

        foreach (tbl[i]) begin
            apply(tbl[i].p, tbl[i].v, tbl[i].po, tbl[i].n, tbl[i].fl, tbl[i].cl);
            tag = $sformatf("vec%0d", i);
            chk({tag, " depth"}, 64'(depth), 64'(tbl[i].e_depth));
            chk({tag, " top0"},  64'(top_0), 64'(tbl[i].e_top0));
            chk({tag, " top1"},  64'(top_1), 64'(tbl[i].e_top1));
            chk({tag, " empty"}, 64'(empty), 64'(tbl[i].e_depth == 0));
            chk({tag, " full"},  64'(full),  64'(tbl[i].e_depth == D));
            chk({tag, " max"},   64'(max_depth), 64'(tbl[i].e_max));
            chk({tag, " ovf"},   64'(err_ovf), 64'(tbl[i].e_ovf));
            chk({tag, " unf"},   64'(err_unf), 64'(tbl[i].e_unf));
        end

        // Asynchronous reset asserted mid-cycle at depth 2, with both errors
        // set. The reset values must appear before the next clock edge.
        #2 rst = 1'b1;
        model_reset();
        #1 check_reset_values("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        apply(1, 35'h5, 0, 11'd0, 0, 0);
        chk("post_rst depth", 64'(depth), 64'd1);
        chk("post_rst top0",  64'(top_0), 64'h5);
        chk("post_rst top1",  64'(top_1), 64'h0);
        check_model("post_rst");

        // Randomized traffic checked against the reference model.
        for (int k = 0; k < N_RND; k++) begin
            rv  = {$urandom(), $urandom()};
            rp  = ($urandom_range(0, 99) < 55);
            rpo = ($urandom_range(0, 99) < 45);
            rn  = ($urandom_range(0, 99) < 6) ? PW'($urandom_range(0, 2047))
                                              : PW'($urandom_range(0, 5));
            rfl = ($urandom_range(0, 99) < 4);
            rcl = ($urandom_range(0, 99) < 5);
            apply(rp, rv[W-1:0], rpo, rn, rfl, rcl);
            check_model($sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
